// File: rtl/registry_lookup_arbiter.sv
// rtl/registry_lookup_arbiter.sv - round-robin arbiter sharing one class-registry lookup engine
module registry_lookup_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ID_W-1:0]   req_id,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic                      eng_valid,
   output logic [ID_W-1:0]           eng_id,
   input  logic                      eng_ready,
   input  logic                      eng_rsp_valid,
   input  logic [DATA_W-1:0]         eng_rsp_data,
   input  logic                      eng_rsp_err,
   output logic                      busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t            state;
   state_t            state_n;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  owner;
   logic [7:0]        timer;
   logic              timed_out;
   logic [NUM_REQ-1:0] owner_oh;

   logic              hi_any;
   logic              lo_any;
   logic [PTR_W-1:0]  hi_idx;
   logic [PTR_W-1:0]  lo_idx;
   logic [ID_W-1:0]   hi_id;
   logic [ID_W-1:0]   lo_id;
   logic              grant_any;
   logic [PTR_W-1:0]  grant_idx;
   logic [ID_W-1:0]   grant_id;

   assign timed_out = (timer == 8'(TIMEOUT));
   assign owner_oh  = NUM_REQ'(1) << owner;
   assign busy      = (state != S_IDLE);

   // Rotating priority: lowest pending requester at or above rr_ptr wins, otherwise wrap to the lowest overall
   always_comb begin
      hi_any = 1'b0;
      lo_any = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      hi_id  = '0;
      lo_id  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_any = 1'b1;
            lo_idx = PTR_W'(i);
            lo_id  = req_id[i*ID_W +: ID_W];
         end
         if (req_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
            hi_any = 1'b1;
            hi_idx = PTR_W'(i);
            hi_id  = req_id[i*ID_W +: ID_W];
         end
      end
      grant_any = lo_any;
      grant_idx = hi_any ? hi_idx : lo_idx;
      grant_id  = hi_any ? hi_id  : lo_id;
   end

   // Next state and the combinational accept pulse (suppressed while reset is asserted)
   always_comb begin
      state_n   = state;
      req_ready = '0;
      case (state)
         S_IDLE: begin
            if (grant_any && !rst) begin
               state_n   = S_ISSUE;
               req_ready = NUM_REQ'(1) << grant_idx;
            end
         end
         S_ISSUE: begin
            if (eng_ready) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (eng_rsp_valid || timed_out) state_n = S_DONE;
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Query latch, engine handshake, wait timer, response capture and pointer advance
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         owner     <= '0;
         timer     <= '0;
         eng_valid <= 1'b0;
         eng_id    <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  owner     <= grant_idx;
                  eng_id    <= grant_id;
                  eng_valid <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (eng_ready) begin
                  eng_valid <= 1'b0;
                  timer     <= '0;
               end
            end
            S_WAIT: begin
               timer <= timer + 8'd1;
               // A strobe landing on the timeout cycle still wins and carries its data
               if (eng_rsp_valid) begin
                  rsp_valid <= owner_oh;
                  rsp_data  <= eng_rsp_data;
                  rsp_err   <= eng_rsp_err;
               end else if (timed_out) begin
                  rsp_valid <= owner_oh;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
               end
            end
            S_DONE: begin
               rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
